// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encodings and latency defaults for md_unit
//
// Purpose: request codes understood by md_unit/md_calc, default busy
//          latencies, and small op-class helpers.
// Ports:   none (package)
package md_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NOP   = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MFHI  = 4'd7;
  localparam md_op_t MD_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  function automatic logic is_mul(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide datapath for md_unit
//
// Purpose: computes the 64-bit HI/LO result of MULT/MULTU/DIV/DIVU from the
//          operands presented at issue time.
// Ports:   A, B        in  32  operands
//          op          in  4   request code (md_pkg)
//          res_hi      out 32  product high word / remainder
//          res_lo      out 32  product low word / quotient
//          div_by_zero out 1   DIV/DIVU with B == 0
module md_calc
  import md_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    prod_u = {32'b0, A} * {32'b0, B};
    // Sign-extending both operands to 64 bits makes the low 64 bits of the
    // product equal to the two's-complement signed product.
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

    // Signed division runs on magnitudes; the most negative value's
    // magnitude 0x80000000 is exact as an unsigned number, so
    // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
    signed_div = (op == MD_DIV);
    mag_a      = (signed_div && A[31]) ? (32'd0 - A) : A;
    mag_b      = (signed_div && B[31]) ? (32'd0 - B) : B;
    // Divide by one when B is zero so the datapath never sees x/0; the
    // result is discarded by the top in that case.
    divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo_u      = mag_a / divisor;
    rem_u      = mag_a % divisor;
    neg_q      = signed_div && (A[31] ^ B[31]);
    neg_r      = signed_div && A[31];

    div_by_zero = is_div(op) && (B == 32'd0);

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_lo = neg_q ? (32'd0 - quo_u) : quo_u;
        res_hi = neg_r ? (32'd0 - rem_u) : rem_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: accepts md requests from EX, holds HI/LO, models the mult/div
//          latency with a down-counter and commits results when it expires.
// Ports:   clk         in  1   pipeline clock
//          reset       in  1   synchronous active-high reset
//          A, B        in  32  operands (rs, rt after forwarding)
//          op          in  4   request code (md_pkg)
//          S           out 32  HI for MFHI, LO for MFLO, else 0 (0 while busy)
//          busy        out 1   mult/div in flight
//          count_down  out 4   remaining busy cycles, 0 when idle
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  output logic [31:0] S,
  output logic        busy,
  output logic [3:0]  count_down
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic [3:0]  cnt;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;

  md_calc u_calc (
    .A           (A),
    .B           (B),
    .op          (op),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi         <= 32'd0;
      lo         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      cnt        <= 4'd0;
    end else if (cnt != 4'd0) begin
      // Requests arriving while busy are dropped; only the countdown runs.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= pending_hi;
        lo <= pending_lo;
      end
    end else begin
      case (op)
        MD_MULT, MD_MULTU: begin
          pending_hi <= res_hi;
          pending_lo <= res_lo;
          cnt        <= MULT_CNT;
        end
        MD_DIV, MD_DIVU: begin
          // Divide by zero still occupies the full latency but commits the
          // current HI/LO, which cannot change while busy.
          pending_hi <= div_by_zero ? hi : res_hi;
          pending_lo <= div_by_zero ? lo : res_lo;
          cnt        <= DIV_CNT;
        end
        MD_MTHI: hi <= A;
        MD_MTLO: lo <= A;
        default: ;
      endcase
    end
  end

  assign busy       = (cnt != 4'd0);
  assign count_down = cnt;

  always_comb begin
    S = 32'd0;
    if (!busy) begin
      if (op == MD_MFHI)      S = hi;
      else if (op == MD_MFLO) S = lo;
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide responder serving the execution stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the EX-stage controller. Holds architectural HI/LO registers and reports a busy flag so the hazard logic can stall dependent instructions. Returns HI/LO reads combinationally into the EX result mux.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (2..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (2..15)

Ports:
- clk  in  1  pipeline clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- A  in  32  operand 1 (rs after forwarding)
- B  in  32  operand 2 (rt after forwarding)
- op  in  4  request code (md_pkg): 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NOP
- S  out  32  read data: HI for MFHI, LO for MFLO, else 0
- busy  out  1  registered; high while a mult/div is in flight
- count_down  out  4  registered remaining busy cycles; 0 when idle

## Operation
- Internal state: HI, LO (32 each), pending_hi, pending_lo (32 each), cnt (4). busy = (cnt != 0); count_down = cnt.
- Idle (cnt == 0), op sampled each rising edge:
  - MULT: {pending_hi,pending_lo} = signed A*B (64-bit); cnt ← MULT_CYCLES.
  - MULTU: unsigned 64-bit product; cnt ← MULT_CYCLES.
  - DIV: LO = A/B signed, truncated toward zero; HI = remainder, sign of A. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. cnt ← DIV_CYCLES.
  - DIVU: unsigned quotient/remainder; cnt ← DIV_CYCLES.
  - B == 0 on DIV/DIVU: full DIV_CYCLES busy period; HI/LO unchanged at commit.
  - MTHI: HI ← A. MTLO: LO ← A. Both take effect at the edge, no busy.
  - MFHI/MFLO/NOP: no state change.
- Busy (cnt != 0):
  - cnt decrements every edge.
  - On the edge where cnt goes 1→0: HI ← pending_hi, LO ← pending_lo.
  - Any op presented while busy is ignored (no state change); S = 0 while busy. Upstream hazard logic stalls md ops while busy.
- S is combinational from op and HI/LO. It reflects HI/LO as currently registered.
- Reset: HI, LO, pending_*, cnt ← 0. Takes priority over everything and aborts any in-flight operation; no commit occurs.

## Timing
- Issue at edge k: busy = 1 and count_down = N (N = MULT_CYCLES or DIV_CYCLES) during cycle k+1. count_down = 1 during cycle k+N. busy = 0 from cycle k+N+1.
- New HI/LO visible to MFHI/MFLO in cycle k+N+1. A new mult/div is accepted at the edge ending cycle k+N+1 at the earliest.
- busy is not asserted in the issue cycle k. The hazard unit stalls on (busy | op ∈ {MULT, MULTU, DIV, DIVU}) for dependent md instructions in the stage behind.
- MTHI/MTLO at edge k: the new value is read by MFHI/MFLO in cycle k+1.
- Reset asserted during cycle j: all outputs zero from cycle j+1 (S = 0 for any op, busy = 0, count_down = 0).

## Structure
- Package md_pkg: op encodings (MD_NOP … MD_MFLO) and default latency constants.
- One natural sub-module: md_calc, purely combinational. Inputs A, B, op. Outputs res_hi, res_lo, div_by_zero.
- Top holds the counter, HI/LO, pending registers and the S mux.
- Target size: ~150–250 lines.

## Test plan
- MULT A = 0xFFFFFFFE (−2), B = 3 → busy for 5 cycles, count_down 5,4,3,2,1. MFHI in cycle 6 → 0xFFFFFFFF; MFLO → 0xFFFFFFFA.
- MULTU A = 0xFFFFFFFF, B = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 after 5 busy cycles.
- DIV A = −7 (0xFFFFFFF9), B = 2 → 10 busy cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI A = 0x1234 then DIVU A = 5, B = 0 → 10 busy cycles, HI still 0x1234. MTLO presented during busy is ignored; S = 0 while busy.
- MULT issued, reset asserted in 3rd busy cycle → next cycle busy = 0, count_down = 0, MFHI = 0, MFLO = 0. No late commit afterwards.
- Back-to-back: MULT accepted, then DIVU presented in cycle k+N+1 → accepted at that edge; MFLO in cycle k+N+1 returns the MULT result.
